// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash Wishbone reader.
// Frame layout: READ command, 24-bit address, 32 data bits.
package spi_flash_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         SPI_FRAME_BITS = 64;
    localparam int         ADDR_BITS      = 24;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    // Flash bytes arrive lowest-address first; the bus word is little-endian.
    function automatic logic [31:0] le_word(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider producing one-cycle rise/fall strobes.
// Held cleared whenever it is not enabled.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          phase;
    logic          tick;

    assign tick       = en && (cnt == CW'(CLK_DIV - 1));
    assign rise_pulse = tick && !phase;
    assign fall_pulse = tick && phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_flash_wb_reader.sv
// Read-only Wishbone classic slave fetching 32-bit words from SPI NOR flash.
// Each bus read becomes one mode-0 READ (0x03) transaction.
module spi_flash_wb_reader
    import spi_flash_pkg::*;
#(
    parameter int          CLK_DIV        = 2,
    parameter int          CS_HIGH_CYCLES = 4,
    parameter logic [23:0] FLASH_OFFSET   = 24'h000000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        spi_cs_n_o,
    output logic        spi_sclk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int GW = $clog2(CS_HIGH_CYCLES + 1);

    state_t                 state;
    state_t                 state_n;
    logic [63:0]            shreg;
    logic [31:0]            rx;
    logic [5:0]             bit_cnt;
    logic [GW-1:0]          gap_cnt;
    logic                   aborted;
    logic                   cs_n;
    logic                   sclk;
    logic                   mosi;
    logic                   ack;
    logic                   err;
    logic [31:0]            dat;
    logic                   rise_pulse;
    logic                   fall_pulse;
    logic [ADDR_BITS-1:0]   flash_addr;
    logic [63:0]            frame;
    logic                   wb_req;
    logic                   rd_req;
    logic                   wr_req;
    logic                   last_fall;
    logic                   gap_done;
    logic                   unused_ok;

    assign wb_req     = wb_cyc_i && wb_stb_i;
    assign rd_req     = wb_req && !wb_we_i && !ack && !err;
    assign wr_req     = wb_req && wb_we_i && !err;
    assign flash_addr = FLASH_OFFSET + {wb_adr_i[23:2], 2'b00};
    assign frame      = {FLASH_CMD_READ, flash_addr, 32'h0};
    assign last_fall  = fall_pulse && (bit_cnt == 6'(SPI_FRAME_BITS - 1));
    assign gap_done   = gap_cnt == GW'(CS_HIGH_CYCLES - 1);
    assign unused_ok  = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:24],
                          wb_adr_i[1:0], shreg[63]};

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .en         (state == SHIFT),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (rd_req)    state_n = SHIFT;
            SHIFT:   if (last_fall) state_n = GAP;
            GAP:     if (gap_done)  state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shreg   <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            aborted <= 1'b0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            dat     <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_req) begin
                        shreg   <= frame;
                        mosi    <= frame[63];
                        cs_n    <= 1'b0;
                        sclk    <= 1'b0;
                        bit_cnt <= '0;
                        aborted <= 1'b0;
                    end else if (wr_req) begin
                        err <= 1'b1;
                    end
                end
                SHIFT: begin
                    // A dropped cycle still finishes the frame, just unacked.
                    if (!wb_req) aborted <= 1'b1;
                    if (rise_pulse) begin
                        sclk <= 1'b1;
                        if (bit_cnt[5]) rx <= {rx[30:0], spi_miso_i};
                    end
                    if (fall_pulse) begin
                        sclk    <= 1'b0;
                        bit_cnt <= bit_cnt + 6'd1;
                        shreg   <= {shreg[62:0], 1'b0};
                        mosi    <= shreg[62];
                        if (last_fall) begin
                            cs_n    <= 1'b1;
                            mosi    <= 1'b0;
                            gap_cnt <= '0;
                            if (wb_req && !aborted) begin
                                ack <= 1'b1;
                                dat <= le_word(rx);
                            end
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                default: begin
                    cs_n <= 1'b1;
                end
            endcase
        end
    end

    assign wb_dat_o   = dat;
    assign wb_ack_o   = ack;
    assign wb_err_o   = err;
    assign spi_cs_n_o = cs_n;
    assign spi_sclk_o = sclk;
    assign spi_mosi_o = mosi;

endmodule

// File: tb/tb_spi_flash_wb_reader.sv
// Directed bench for spi_flash_wb_reader with a behavioural SPI NOR model.
// Instance 0 uses a zero flash offset, instance 1 uses 24'h100000.
module tb_spi_flash_wb_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat = 32'h0;
    logic [3:0]  wb_sel = 4'hF;
    logic        wb_we;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [1:0]  cs_n;
    logic [1:0]  sclk;
    logic [1:0]  mosi;
    logic [1:0]  miso = 2'b00;
    logic [31:0] dat0;
    logic [31:0] dat1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem [logic [23:0]];
    int          bits [2];
    logic [31:0] hdr  [2];
    logic [1:0]  pcs   = 2'b11;
    logic [1:0]  psclk = 2'b00;

    always #5 clk = ~clk;

    spi_flash_wb_reader dut0 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_sel_i   (wb_sel),
        .wb_we_i    (wb_we),
        .wb_cyc_i   (cyc[0]),
        .wb_stb_i   (stb[0]),
        .wb_dat_o   (dat0),
        .wb_ack_o   (ack[0]),
        .wb_err_o   (err[0]),
        .spi_cs_n_o (cs_n[0]),
        .spi_sclk_o (sclk[0]),
        .spi_mosi_o (mosi[0]),
        .spi_miso_i (miso[0])
    );

    spi_flash_wb_reader #(
        .FLASH_OFFSET (24'h100000)
    ) dut1 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_sel_i   (wb_sel),
        .wb_we_i    (wb_we),
        .wb_cyc_i   (cyc[1]),
        .wb_stb_i   (stb[1]),
        .wb_dat_o   (dat1),
        .wb_ack_o   (ack[1]),
        .wb_err_o   (err[1]),
        .spi_cs_n_o (cs_n[1]),
        .spi_sclk_o (sclk[1]),
        .spi_mosi_o (mosi[1]),
        .spi_miso_i (miso[1])
    );

    function automatic logic [7:0] rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'hFF;
    endfunction

    // Flash model: header captured on SCLK rises, data driven on falls.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (pcs[g] && !cs_n[g]) begin
                bits[g] = 0;
                hdr[g]  = 32'h0;
            end
            if (!cs_n[g] && !psclk[g] && sclk[g]) begin
                if (bits[g] < 32) hdr[g] = {hdr[g][30:0], mosi[g]};
                bits[g]++;
            end
            if (!cs_n[g] && psclk[g] && !sclk[g] &&
                bits[g] >= 32 && bits[g] < 64) begin
                int          j;
                logic [23:0] a;
                logic [7:0]  b;
                j = bits[g] - 32;
                a = hdr[g][23:0] + 24'(j / 8);
                b = rd(a);
                miso[g] = b[7 - (j % 8)];
            end
            pcs[g]   = cs_n[g];
            psclk[g] = sclk[g];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic run_read(input int g, input logic [31:0] adr,
                            output int ack_at, output int low_n);
        ack_at = -1;
        low_n  = 0;
        wb_adr = adr;
        wb_we  = 1'b0;
        cyc[g] = 1'b1;
        stb[g] = 1'b1;
        for (int n = 1; n <= 400 && ack_at < 0; n++) begin
            step();
            if (!cs_n[g]) low_n++;
            if (ack[g]) ack_at = n;
        end
        cyc[g] = 1'b0;
        stb[g] = 1'b0;
    endtask

    initial begin
        int          ack_at;
        int          low_n;
        int          acks;
        int          rise_n;
        int          fall_n;
        logic        cs_prev;
        logic        done;
        logic [31:0] d1;
        logic [31:0] d2;

        mem[24'h000000] = 8'h13; mem[24'h000001] = 8'h05;
        mem[24'h000002] = 8'h00; mem[24'h000003] = 8'h00;
        mem[24'h000004] = 8'hDE; mem[24'h000005] = 8'hAD;
        mem[24'h000006] = 8'hBE; mem[24'h000007] = 8'hEF;
        mem[24'h000008] = 8'hAA; mem[24'h000009] = 8'hBB;
        mem[24'h00000A] = 8'hCC; mem[24'h00000B] = 8'hDD;
        mem[24'h100104] = 8'h11; mem[24'h100105] = 8'h22;
        mem[24'h100106] = 8'h33; mem[24'h100107] = 8'h44;
        bits[0] = 0; bits[1] = 0;
        hdr[0]  = 32'h0; hdr[1] = 32'h0;

        rst = 1'b1; cyc = 2'b00; stb = 2'b00; wb_we = 1'b0; wb_adr = 32'h0;
        idle(3);
        chk("rst_cs_n", 64'(cs_n), 64'h3);
        chk("rst_sclk", 64'(sclk), 64'h0);
        chk("rst_mosi", 64'(mosi), 64'h0);
        chk("rst_ack",  64'(ack),  64'h0);
        chk("rst_err",  64'(err),  64'h0);
        chk("rst_dat",  64'(dat0), 64'h0);
        rst = 1'b0;

        // Basic read at address 0
        run_read(0, 32'h0, ack_at, low_n);
        chk("t1_ack_at", 64'(ack_at), 64'd257);
        chk("t1_dat",    64'(dat0),   64'h00000513);
        chk("t1_cs_low", 64'(low_n),  64'd256);
        chk("t1_hdr",    64'(hdr[0]), 64'h03000000);
        chk("t1_rises",  64'(bits[0]), 64'd64);

        // Offset instance, unaligned address
        run_read(1, 32'h00000107, ack_at, low_n);
        chk("t2_ack_at", 64'(ack_at), 64'd257);
        chk("t2_hdr",    64'(hdr[1]), 64'h03100104);
        chk("t2_dat",    64'(dat1),   64'h44332211);

        // Back-to-back with stb held
        wb_adr = 32'h4; wb_we = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        acks = 0; rise_n = -1; fall_n = -1; cs_prev = 1'b1;
        d1 = 32'h0; d2 = 32'h0;
        for (int i = 1; i <= 700 && acks < 2; i++) begin
            step();
            if (ack[0]) begin
                acks++;
                if (acks == 1) begin
                    d1 = dat0;
                    wb_adr = 32'h0;
                end else begin
                    d2 = dat0;
                end
            end
            if (!cs_prev && cs_n[0] && rise_n < 0) rise_n = i;
            if (cs_prev && !cs_n[0] && rise_n >= 0 && fall_n < 0) fall_n = i;
            cs_prev = cs_n[0];
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack[0]) acks++;
        end
        chk("t3_acks", 64'(acks), 64'd2);
        chk("t3_d1",   64'(d1),   64'hEFBEADDE);
        chk("t3_d2",   64'(d2),   64'h00000513);
        chk("t3_gap",  64'((fall_n - rise_n) >= 5 && rise_n > 0), 64'd1);

        // Write gets a single-cycle error
        idle(8);
        cyc[0] = 1'b1; stb[0] = 1'b1; wb_we = 1'b1;
        step();
        chk("t4_err",  64'(err[0]),  64'd1);
        chk("t4_ack",  64'(ack[0]),  64'd0);
        chk("t4_cs_n", 64'(cs_n[0]), 64'd1);
        cyc[0] = 1'b0; stb[0] = 1'b0; wb_we = 1'b0;
        step();
        chk("t4_err_off", 64'(err[0]), 64'd0);
        low_n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!cs_n[0]) low_n++;
        end
        chk("t4_cs_quiet", 64'(low_n), 64'd0);

        // Cycle dropped mid-frame
        wb_adr = 32'h8; cyc[0] = 1'b1; stb[0] = 1'b1;
        idle(100);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        acks = 0; done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (ack[0]) acks++;
            if (cs_n[0]) done = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (ack[0]) acks++;
        end
        chk("t5_done",  64'(done),    64'd1);
        chk("t5_acks",  64'(acks),    64'd0);
        chk("t5_rises", 64'(bits[0]), 64'd64);
        chk("t5_hdr",   64'(hdr[0]),  64'h03000008);
        chk("t5_dat",   64'(dat0),    64'h00000513);

        // Reset in the middle of a frame
        idle(8);
        wb_adr = 32'h4; cyc[0] = 1'b1; stb[0] = 1'b1;
        idle(50);
        rst = 1'b1;
        step();
        chk("t6_cs_n", 64'(cs_n[0]), 64'd1);
        chk("t6_sclk", 64'(sclk[0]), 64'd0);
        chk("t6_mosi", 64'(mosi[0]), 64'd0);
        chk("t6_ack",  64'(ack[0]),  64'd0);
        chk("t6_dat",  64'(dat0),    64'h0);
        rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack[0]) acks++;
        end
        chk("t6_no_ack", 64'(acks), 64'd0);
        run_read(0, 32'h0, ack_at, low_n);
        chk("t6_ack_at", 64'(ack_at), 64'd257);
        chk("t6_dat2",   64'(dat0),   64'h00000513);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
